// File: rtl/aes_decrypt_iter.sv
// Iterative AES inverse cipher: captures one block and key, expands the key
// schedule into a round-key bank, then applies one inverse round per clock.
module aes_decrypt_iter #(
    parameter int Nk = 4,
    parameter int Nr = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [127:0]     cipher_in,
    input  logic [32*Nk-1:0] key_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [127:0]     plain_out,
    output logic             busy
);
    localparam int NW = 4 * (Nr + 1);
    localparam int AW = $clog2(NW);
    localparam int CW = $clog2(Nr + 1);
    localparam int KW = (Nk > 1) ? $clog2(Nk) : 1;

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_KEXP  = 3'd1,
        S_ADDK  = 3'd2,
        S_ROUND = 3'd3,
        S_FINAL = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    // Table entry x sits at bit offset (255-x)*8, which is {~x, 3'b000}.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[{~x, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        return INV_SBOX[{~x, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [3:0] c);
        logic [7:0] m2, m4, m8;
        m2 = xtime(a);
        m4 = xtime(m2);
        m8 = xtime(m4);
        return (c[3] ? m8 : 8'h00) ^ (c[2] ? m4 : 8'h00) ^ (c[1] ? m2 : 8'h00) ^ (c[0] ? a : 8'h00);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = 128'h0;
        for (int i = 0; i < 16; i++) begin
            o[8*i +: 8] = inv_sbox(s[8*i +: 8]);
        end
        return o;
    endfunction

    // Byte 4c+r holds row r of column c; row r rotates right by r columns.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = 128'h0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = 128'h0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = gf_mul(a0, 4'he) ^ gf_mul(a1, 4'hb) ^ gf_mul(a2, 4'hd) ^ gf_mul(a3, 4'h9);
            o[119-32*c -: 8] = gf_mul(a0, 4'h9) ^ gf_mul(a1, 4'he) ^ gf_mul(a2, 4'hb) ^ gf_mul(a3, 4'hd);
            o[111-32*c -: 8] = gf_mul(a0, 4'hd) ^ gf_mul(a1, 4'h9) ^ gf_mul(a2, 4'he) ^ gf_mul(a3, 4'hb);
            o[103-32*c -: 8] = gf_mul(a0, 4'hb) ^ gf_mul(a1, 4'hd) ^ gf_mul(a2, 4'h9) ^ gf_mul(a3, 4'he);
        end
        return o;
    endfunction

    state_t          r_fsm, w_next;
    logic [127:0]    r_state;
    logic [31:0]     r_w [0:NW-1];
    logic [AW-1:0]   r_idx;
    logic [KW-1:0]   r_kmod;
    logic [7:0]      r_rcon;
    logic [CW-1:0]   r_cnt;
    logic [127:0]    r_plain;
    logic            r_out_valid;

    logic [31:0]     w_prev, w_old, w_sw_in, w_sw_out, w_temp;
    logic [AW-1:0]   w_rk_base;
    logic [127:0]    w_rk, w_isb, w_ark, w_imc;

    assign w_prev    = r_w[r_idx - AW'(1)];
    assign w_old     = r_w[r_idx - AW'(Nk)];
    assign w_sw_out  = sub_word(w_sw_in);
    assign w_rk_base = AW'({r_cnt, 2'b00});
    assign w_rk      = {r_w[w_rk_base], r_w[w_rk_base | AW'(1)],
                        r_w[w_rk_base | AW'(2)], r_w[w_rk_base | AW'(3)]};
    assign w_isb     = inv_sub_bytes(inv_shift_rows(r_state));
    assign w_ark     = w_isb ^ w_rk;
    assign w_imc     = inv_mix_columns(w_ark);

    assign in_ready  = (r_fsm == S_IDLE);
    assign busy      = (r_fsm != S_IDLE);
    assign out_valid = r_out_valid;
    assign plain_out = r_plain;

    // Rotate the SubWord input only on words that start a new key block.
    always_comb begin
        w_sw_in = w_prev;
        if (r_kmod == {KW{1'b0}}) begin
            w_sw_in = {w_prev[23:0], w_prev[31:24]};
        end else begin
            w_sw_in = w_prev;
        end
    end

    // Key-schedule temp word selection.
    always_comb begin
        w_temp = w_prev;
        if (r_kmod == {KW{1'b0}}) begin
            w_temp = w_sw_out ^ {r_rcon, 24'h000000};
        end else if ((Nk == 8) && (r_kmod == KW'(4))) begin
            w_temp = w_sw_out;
        end else begin
            w_temp = w_prev;
        end
    end

    // Control state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fsm <= S_IDLE;
        end else begin
            r_fsm <= w_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next = r_fsm;
        case (r_fsm)
            S_IDLE:  w_next = in_valid ? S_KEXP : S_IDLE;
            S_KEXP:  w_next = (r_idx == AW'(NW - 1)) ? S_ADDK : S_KEXP;
            S_ADDK:  w_next = (r_cnt == CW'(1)) ? S_FINAL : S_ROUND;
            S_ROUND: w_next = (r_cnt == CW'(1)) ? S_FINAL : S_ROUND;
            S_FINAL: w_next = S_DONE;
            S_DONE:  w_next = out_ready ? S_IDLE : S_DONE;
            default: w_next = S_IDLE;
        endcase
    end

    // Datapath: capture, key expansion, inverse rounds and output hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= 128'h0;
            r_idx       <= {AW{1'b0}};
            r_kmod      <= {KW{1'b0}};
            r_rcon      <= 8'h00;
            r_cnt       <= {CW{1'b0}};
            r_plain     <= 128'h0;
            r_out_valid <= 1'b0;
            for (int j = 0; j < NW; j++) begin
                r_w[j] <= 32'h0;
            end
        end else begin
            case (r_fsm)
                S_IDLE: begin
                    if (in_valid) begin
                        r_state <= cipher_in;
                        for (int j = 0; j < Nk; j++) begin
                            r_w[j] <= key_in[32*(Nk-1-j) +: 32];
                        end
                        r_idx  <= AW'(Nk);
                        r_kmod <= {KW{1'b0}};
                        r_rcon <= 8'h01;
                        r_cnt  <= CW'(Nr);
                    end
                end
                S_KEXP: begin
                    r_w[r_idx] <= w_old ^ w_temp;
                    r_idx      <= r_idx + AW'(1);
                    if (r_kmod == KW'(Nk - 1)) begin
                        r_kmod <= {KW{1'b0}};
                    end else begin
                        r_kmod <= r_kmod + KW'(1);
                    end
                    if (r_kmod == {KW{1'b0}}) begin
                        r_rcon <= xtime(r_rcon);
                    end
                end
                S_ADDK: begin
                    r_state <= r_state ^ w_rk;
                    r_cnt   <= r_cnt - CW'(1);
                end
                S_ROUND: begin
                    r_state <= w_imc;
                    r_cnt   <= r_cnt - CW'(1);
                end
                S_FINAL: begin
                    r_state     <= w_ark;
                    r_plain     <= w_ark;
                    r_out_valid <= 1'b1;
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_aes_decrypt_iter.sv
// Bench for aes_decrypt_iter: AES-128/192/256 instances in parallel, checked
// every cycle against a timing model whose expected plaintexts come from a forward cipher.
module tb_aes_decrypt_iter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst       = 1'b1;
    logic              in_valid  = 1'b0;
    logic              out_ready = 1'b1;
    logic [2:0][127:0] d_cipher;
    logic [2:0][255:0] d_key;
    logic [2:0][127:0] d_plain;
    logic [2:0]        w_in_ready, w_out_valid, w_busy;
    logic [2:0][127:0] w_plain;

    aes_decrypt_iter #(.Nk(4), .Nr(10)) u_aes128 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(w_in_ready[0]),
        .cipher_in(d_cipher[0]), .key_in(d_key[0][255:128]), .out_valid(w_out_valid[0]),
        .out_ready(out_ready), .plain_out(w_plain[0]), .busy(w_busy[0]));
    aes_decrypt_iter #(.Nk(6), .Nr(12)) u_aes192 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(w_in_ready[1]),
        .cipher_in(d_cipher[1]), .key_in(d_key[1][255:64]), .out_valid(w_out_valid[1]),
        .out_ready(out_ready), .plain_out(w_plain[1]), .busy(w_busy[1]));
    aes_decrypt_iter #(.Nk(8), .Nr(14)) u_aes256 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(w_in_ready[2]),
        .cipher_in(d_cipher[2]), .key_in(d_key[2]), .out_valid(w_out_valid[2]),
        .out_ready(out_ready), .plain_out(w_plain[2]), .busy(w_busy[2]));

    int checks = 0;
    int errors = 0;
    logic [7:0] sb [256];

    // Model state: what each instance must show after the most recent edge.
    logic [2:0]   m_busy, m_valid;
    int           m_cnt   [3];
    logic [127:0] m_plain [3];
    logic [127:0] m_exp   [3];

    localparam logic [255:0] KAT_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] KAT_PT  = 128'h00112233445566778899aabbccddeeff;
    logic [2:0][127:0] kat_ct;

    task automatic chk(input string name, input int k, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %h expected %h at t=%0t", name, k, act, exp, $time);
        end
    endtask

    function automatic int lat(input int k);
        int nk, nr;
        nk = 4 + 2 * k;
        nr = nk + 6;
        return (4 * (nr + 1) - nk) + nr + 1;
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
    endfunction

    // Forward AES; the bench feeds the DUT its ciphertext and expects the plaintext back.
    function automatic logic [127:0] aes_enc(input logic [127:0] p, input logic [255:0] key, input int nk);
        int nr;
        logic [31:0]  w [60];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   rc, a0, a1, a2, a3;
        logic [31:0]  tmp;
        logic [127:0] o;
        nr = nk + 6;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            tmp = w[i-1];
            if (i % nk == 0) begin
                tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
                rc  = gmul(rc, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                tmp = subw(tmp);
            end
            w[i] = w[i-nk] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = p[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
        for (int r = 1; r <= nr; r++) begin
            for (int c = 0; c < 4; c++)
                for (int q = 0; q < 4; q++) t[4*c+q] = sb[s[4*((c+q)%4)+q]];
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                if (r < nr) begin
                    t[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                    t[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                    t[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                    t[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                end
            end
            for (int i = 0; i < 16; i++) s[i] = t[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
        end
        o = 128'h0;
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
        return o;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_job(input int k, input logic [127:0] p, input logic [255:0] key);
        d_plain[k]  = p;
        d_key[k]    = key;
        d_cipher[k] = aes_enc(p, key, 4 + 2 * k);
    endtask

    task automatic scramble();
        for (int k = 0; k < 3; k++) set_job(k, rand128(), {rand128(), rand128()});
    endtask

    task automatic set_kat();
        for (int k = 0; k < 3; k++) begin
            d_cipher[k] = kat_ct[k];
            d_key[k]    = KAT_KEY;
            d_plain[k]  = KAT_PT;
        end
    endtask

    task automatic wait_idle(input string name, input int limit);
        int n;
        n = 0;
        while (((m_busy | w_busy) != 3'b000) && n < limit) begin
            tick();
            n++;
        end
        if ((m_busy | w_busy) != 3'b000) begin
            checks++;
            errors++;
            $display("FAIL %s: timeout, busy=%b expected %b", name, w_busy, 3'b000);
        end
    endtask

    // Compare DUT against the model, then advance the model to the next edge.
    initial begin
        forever begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                if (rst) begin
                    m_busy[k]  = 1'b0;
                    m_valid[k] = 1'b0;
                    m_cnt[k]   = 0;
                    m_plain[k] = 128'h0;
                end
                chk("in_ready", k, 128'(w_in_ready[k]), 128'(!m_busy[k]));
                chk("busy", k, 128'(w_busy[k]), 128'(m_busy[k]));
                chk("out_valid", k, 128'(w_out_valid[k]), 128'(m_valid[k]));
                chk("plain_out", k, w_plain[k], m_plain[k]);
                if (!rst) begin
                    if (!m_busy[k]) begin
                        if (in_valid) begin
                            m_busy[k] = 1'b1;
                            m_cnt[k]  = 0;
                            m_exp[k]  = d_plain[k];
                        end
                    end else if (!m_valid[k]) begin
                        m_cnt[k]++;
                        if (m_cnt[k] == lat(k)) begin
                            m_valid[k] = 1'b1;
                            m_plain[k] = m_exp[k];
                        end
                    end else if (out_ready) begin
                        m_valid[k] = 1'b0;
                        m_busy[k]  = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        int seen [3];
        int n;
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
        end
        kat_ct[0] = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        kat_ct[1] = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
        kat_ct[2] = 128'h8ea2b7ca516745bfeafc49904b496089;
        for (int k = 0; k < 3; k++) chk("model_enc_kat", k, aes_enc(KAT_PT, KAT_KEY, 4 + 2 * k), kat_ct[k]);
        chk("model_enc_fips", 0, aes_enc(128'h3243f6a8885a308d313198a2e0370734,
            {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 4), 128'h3925841d02dc09fbdc118597196a0b32);

        scramble();
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Known-answer vectors with exact latency measurement.
        set_kat();
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        scramble();
        for (int k = 0; k < 3; k++) seen[k] = 0;
        for (int c = 1; c <= 80; c++) begin
            tick();
            for (int k = 0; k < 3; k++)
                if (w_out_valid[k] && seen[k] == 0) seen[k] = c;
        end
        for (int k = 0; k < 3; k++) chk("latency", k, 128'(seen[k]), 128'(51 + 8 * k));
        wait_idle("kat", 50);

        // Backpressure: hold results while a different block is offered.
        out_ready = 1'b0;
        scramble();
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        scramble();
        n = 0;
        while (((m_valid & w_out_valid) != 3'b111) && n < 200) begin
            tick();
            n++;
        end
        if ((m_valid & w_out_valid) != 3'b111) begin
            checks++;
            errors++;
            $display("FAIL bp_wait_valid: out_valid=%b expected %b", w_out_valid, 3'b111);
        end
        for (int c = 0; c < 20; c++) begin
            in_valid = ~in_valid;
            scramble();
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        wait_idle("backpressure", 10);

        // Reset in the middle of key expansion, then a fresh job.
        set_kat();
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        scramble();
        repeat (10) tick();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        set_kat();
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        scramble();
        wait_idle("after_reset", 100);

        // Back-to-back jobs with in_valid held high.
        set_kat();
        in_valid = 1'b1;
        tick();
        d_cipher[0] = 128'h3925841d02dc09fbdc118597196a0b32;
        d_key[0]    = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
        d_plain[0]  = 128'h3243f6a8885a308d313198a2e0370734;
        for (int k = 1; k < 3; k++) set_job(k, rand128(), {rand128(), rand128()});
        repeat (70) tick();
        in_valid = 1'b0;
        scramble();
        wait_idle("back_to_back", 100);

        // Random traffic with random backpressure.
        for (int c = 0; c < 600; c++) begin
            in_valid  = ($urandom_range(3) == 0);
            out_ready = $urandom_range(1) == 1;
            for (int k = 0; k < 3; k++)
                if ($urandom_range(7) == 0) set_job(k, rand128(), {rand128(), rand128()});
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_idle("random", 200);
        repeat (2) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
